mul4_seq: RTL and testbench
===========================

MUL4_SEQ -- requirements
Module: mul4_seq

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 start  input  1  request to begin a multiply; sampled only when busy=0.
REQ-005 a  input  4  multiplicand, unsigned; captured on the accepting edge.
REQ-006 b  input  4  multiplier, unsigned; captured on the accepting edge.
REQ-007 busy  output  1  high while a multiply is in progress (state RUN).
REQ-008 done  output  1  single-cycle pulse marking p valid for the just-finished multiply.
REQ-009 p  output  8  unsigned product a*b; holds its value until the next completion.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE, held in a registered state vector.
REQ-011 IDLE: start=1 SHALL go to RUN, load mcand<=a, mq<=b, acc<=0, cnt<=0; start=0 SHALL stay in IDLE.
REQ-012 RUN, each edge: if mq[0]=1, then {c,sum} = acc+mcand, else {c,sum} = {0,acc}; then {acc,mq} <= {c,sum,mq}>>1; cnt <= cnt+1.
REQ-013 The RUN addition SHALL use a 4-bit ripple-carry adder of full adders from the team gate library, with carry-out exposed; no behavioural "+" on the datapath.
REQ-014 RUN SHALL last exactly 4 edges; on the 4th RUN edge (cnt=3) p <= {acc,mq} after the shift, done <= 1, state <= DONE.
REQ-015 Latency: start sampled at edge E0 -> busy=1 after E0..E4, p valid and done=1 after E4, done=0 after E5.
REQ-016 DONE lasts one cycle; start=1 in DONE SHALL be accepted exactly as in IDLE (back-to-back, no bubble); otherwise go to IDLE.
REQ-017 start while busy=1 SHALL be ignored: no reload, no latency change, no effect on a later result.
REQ-018 a and b changing during RUN SHALL NOT affect the result.
REQ-019 The product SHALL be exact for all 256 operand pairs; max 15*15=225 (0xE1) with no truncation.
REQ-020 done SHALL never be high for two consecutive cycles unless two multiplies complete on consecutive edges (impossible without MUL4_SEQ_EARLY_DONE_EN).
REQ-021 busy and done SHALL never be high in the same cycle.

Reset
REQ-022 rst_n=0 at an edge SHALL force state=IDLE, busy=0, done=0, p=8'h00, acc=mq=mcand=cnt=0, with priority over start.
REQ-023 Reset mid-RUN SHALL abandon the operation without a done pulse; the first start after rst_n=1 SHALL behave as from power-up.

Configuration
REQ-024 Macro MUL4_SEQ_EARLY_DONE_EN; undefined: fixed 4-cycle RUN per REQ-014.
REQ-025 Defined: after any RUN edge where the post-shift mq upper bits still to be processed are all zero, p SHALL load the fully aligned product (remaining shifts applied in one step), done SHALL assert, and state SHALL go to DONE.
REQ-026 Defined: RUN length SHALL be (index of highest set bit of b)+1, or 1 for b=0; results SHALL be identical to the undefined build.

Verification
REQ-027 a=15, b=15, start at E0 -> busy high E0..E4, p=8'hE1 and done=1 after E4, done=0 after E5.
REQ-028 a=9, b=6, then a=3, b=5 with start held high in DONE -> p=8'h36 after E4, p=8'h0F after E9, busy low only in DONE cycles.
REQ-029 a=7, b=2 started, start pulsed with a=1, b=1 at E2 -> p=8'h0E after E4, second request not executed.
REQ-030 a=12, b=11 started, rst_n=0 at E2 -> p=0, busy=0, no done; restart a=2, b=3 -> p=8'h06 after 4 RUN edges.
REQ-031 Exhaustive sweep of all 256 a,b pairs, each checked against a*b at its done pulse.
REQ-032 With MUL4_SEQ_EARLY_DONE_EN: a=3, b=1 -> done after E1, p=8'h03; a=5, b=0 -> done after E1, p=0; a=15, b=8 -> done after E4, p=8'h78.

Source files
------------

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier (IDLE/RUN/DONE FSM, one bit per cycle).
// Define MUL4_SEQ_EARLY_DONE_EN to end RUN as soon as no set multiplier bits remain.

module mul4_seq_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module mul4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] p
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t     state;
  logic [3:0] mcand;
  logic [3:0] mq;
  logic [3:0] acc;
  logic [1:0] cnt;

  logic [3:0] addend;
  logic [3:0] sum;
  logic [4:0] carry;
  logic [3:0] acc_nx;
  logic [3:0] mq_nx;
  logic       finish;
  logic [7:0] result;

  // Partial product is the multiplicand gated by the current multiplier LSB.
  assign addend   = mcand & {4{mq[0]}};
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_rca
    mul4_seq_fa u_fa (
      .x  (acc[i]),
      .y  (addend[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // {c,sum,mq} shifted right by one: carry drops into acc MSB, sum LSB into mq MSB.
  assign acc_nx = {carry[4], sum[3:1]};
  assign mq_nx  = {sum[0], mq[3:1]};

`ifdef MUL4_SEQ_EARLY_DONE_EN
  logic [3:0] rem_mask;
  logic [1:0] rem_shift;

  // Low mq bits still holding unprocessed multiplier bits after this edge.
  assign rem_mask  = 4'b0111 >> cnt;
  assign rem_shift = 2'd3 - cnt;
  assign finish    = ((mq_nx & rem_mask) == 4'd0);
  assign result    = {acc_nx, mq_nx} >> rem_shift;
`else
  assign finish = (cnt == 2'd3);
  assign result = {acc_nx, mq_nx};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= 8'h00;
      acc   <= 4'd0;
      mq    <= 4'd0;
      mcand <= 4'd0;
      cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            mcand <= a;
            mq    <= b;
            acc   <= 4'd0;
            cnt   <= 2'd0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc <= acc_nx;
          mq  <= mq_nx;
          cnt <= cnt + 2'd1;
          if (finish) begin
            p     <= result;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul4_seq.sv
// Scoreboard bench for mul4_seq: driver pushes expected products and completion edges, monitor checks.
// Honors MUL4_SEQ_EARLY_DONE_EN for the expected run length.

module tb_mul4_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  mul4_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] prod;
    int         acc_edge;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   free_edge = 0;
  int   tests = 0;
  int   failed = 0;
  logic [7:0] last_p = 8'h00;

  always @(posedge clk) cyc++;

  function automatic int run_len(input logic [3:0] m);
`ifdef MUL4_SEQ_EARLY_DONE_EN
    if (m == 4'd0) return 1;
    for (int k = 3; k >= 0; k--)
      if (m[k]) return k + 1;
    return 1;
`else
    return 4;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_p", p, 8'h00);
      q.delete();
      last_p = 8'h00;
    end else begin
      chk("busy_and_done", {7'd0, busy & done}, 8'd0);
      if (q.size() > 0 && cyc == q[0].due) begin
        chk("done_pulse", {7'd0, done}, 8'd1);
        chk("product", p, q[0].prod);
        last_p = q[0].prod;
        void'(q.pop_front());
      end else begin
        chk("no_done", {7'd0, done}, 8'd0);
        chk("p_hold", p, last_p);
      end
      chk("busy", {7'd0, busy}, {7'd0, (q.size() > 0 && cyc >= q[0].acc_edge)});
    end
  end

  // mode 0: start low while waiting; 1: random start; 2: start held high with next operands.
  task automatic issue(input logic [3:0] x, input logic [3:0] y, input int mode);
    bit   placed = 1'b0;
    exp_t e;
    while (!placed) begin
      @(negedge clk);
      if (cyc + 1 >= free_edge) begin
        a = x;
        b = y;
        start = 1'b1;
        e.prod = 8'(int'(x) * int'(y));
        e.acc_edge = cyc + 1;
        e.due = cyc + 1 + run_len(y);
        q.push_back(e);
        free_edge = e.due + 1;
        placed = 1'b1;
      end else if (mode == 2) begin
        a = x;
        b = y;
        start = 1'b1;
      end else begin
        a = 4'($urandom);
        b = 4'($urandom);
        start = (mode == 1) ? 1'($urandom) : 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'($urandom);
    a = 4'($urandom);
    b = 4'($urandom);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    free_edge = cyc + 1;
  endtask

  task automatic drain();
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && q.size() > 0; k++) @(negedge clk);
    chk("drained", 8'(q.size()), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    free_edge = cyc + 1;

    // Largest operands.
    issue(4'd15, 4'd15, 0);
    drain();

    // Back-to-back with start held high through RUN and DONE.
    issue(4'd9, 4'd6, 0);
    issue(4'd3, 4'd5, 2);
    drain();

    // Extra start pulse mid-run must be ignored.
    issue(4'd7, 4'd2, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1;
    b = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset abandons an operation; restart behaves as from power-up.
    issue(4'd12, 4'd11, 0);
    @(negedge clk);
    start = 1'b0;
    do_reset();
    issue(4'd2, 4'd3, 0);
    drain();

    // Exhaustive sweep with assorted waiting behaviour.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        issue(4'(i), 4'(j), int'($urandom_range(0, 2)));
    drain();

    // Random traffic with occasional resets.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      issue(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
